async_fifo_rd_drain: RTL and testbench

- Synthesizable read-side consumer for the team's asynchronous FIFO; runs entirely in the read clock domain.
- On a start request it pops exactly xfer_len words through the FIFO read port (rempty/rinc/rdata).
- Popped words go into a 2-entry output buffer and are presented on a valid/ready stream, with the final word tagged by m_last.
- It is the hardware counterpart of the write-side push stimulus and replaces testbench pop tasks in integrated builds.

---
 rtl/async_fifo_rd_drain.sv | 165 ++++++++++++++++
 tb/tb_async_fifo_rd_drain.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/async_fifo_rd_drain.sv
// Read-side drain engine for the asynchronous FIFO (read clock domain only).
// After a start request it pops exactly xfer_len words through the FIFO read
// port and presents them on a valid/ready stream through a 2-entry buffer.
// The last word of the transfer is tagged with m_last.
//
// Ports:
//   rclk, rrst_n        read clock, asynchronous active-low reset
//   start, xfer_len     transfer request (sampled in IDLE only) and word count
//   busy, done          transfer in progress / one-cycle completion pulse
//   rempty, rinc, rdata FIFO read port (first-word fall-through)
//   m_valid, m_ready,
//   m_data, m_last      output stream
//   rd_count            words accepted downstream in the current/last transfer
module async_fifo_rd_drain #(
   parameter int unsigned FIFO_DATA_WIDTH = 8,
   parameter int unsigned LEN_WIDTH       = 16
) (
   input  logic                       rclk,
   input  logic                       rrst_n,
   input  logic                       start,
   input  logic [LEN_WIDTH-1:0]       xfer_len,
   output logic                       busy,
   output logic                       done,
   input  logic                       rempty,
   output logic                       rinc,
   input  logic [FIFO_DATA_WIDTH-1:0] rdata,
   output logic                       m_valid,
   input  logic                       m_ready,
   output logic [FIFO_DATA_WIDTH-1:0] m_data,
   output logic                       m_last,
   output logic [LEN_WIDTH-1:0]       rd_count
);

   localparam int unsigned DW = FIFO_DATA_WIDTH;
   localparam int unsigned LW = LEN_WIDTH;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRAIN = 2'd1,
      S_FLUSH = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t          state_q, state_n;
   logic [LW-1:0]   rem_pop_q, rem_pop_n;
   logic [LW-1:0]   rem_out_q, rem_out_n;
   logic [LW-1:0]   rd_count_q, rd_count_n;
   logic [1:0]      occ_q, occ_n;
   logic [DW-1:0]   head_q, head_n;
   logic [DW-1:0]   tail_q, tail_n;
   logic            busy_q, done_q, m_valid_q, m_last_q;
   logic            rinc_c;
   logic            hs_c;

   assign hs_c = m_valid_q & m_ready;

   // Next-state, counters and 2-entry buffer update
   always_comb begin
      state_n    = state_q;
      rem_pop_n  = rem_pop_q;
      rem_out_n  = rem_out_q;
      rd_count_n = rd_count_q;
      occ_n      = occ_q;
      head_n     = head_q;
      tail_n     = tail_q;
      rinc_c     = 1'b0;

      // Buffer is empty in IDLE, so a handshake never collides with a start.
      if (hs_c) begin
         rem_out_n  = rem_out_q - LW'(1);
         rd_count_n = rd_count_q + LW'(1);
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               rem_pop_n  = xfer_len;
               rem_out_n  = xfer_len;
               rd_count_n = '0;
               state_n    = (xfer_len == '0) ? S_DONE : S_DRAIN;
            end
         end
         S_DRAIN: begin
            rinc_c = (rem_pop_q != '0) && !rempty && (occ_q < 2'd2);
            if (rinc_c) begin
               rem_pop_n = rem_pop_q - LW'(1);
               if (rem_pop_q == LW'(1)) state_n = S_FLUSH;
            end
         end
         S_FLUSH: begin
            if ((occ_q == 2'd0) && (rem_out_q == '0)) state_n = S_DONE;
         end
         default: begin
            state_n = S_IDLE;
         end
      endcase

      // Head always holds the presented word; tail only fills when head stalls.
      case (occ_q)
         2'd0: begin
            if (rinc_c) begin
               head_n = rdata;
               occ_n  = 2'd1;
            end
         end
         2'd1: begin
            if (rinc_c && hs_c) begin
               head_n = rdata;
            end else if (rinc_c) begin
               tail_n = rdata;
               occ_n  = 2'd2;
            end else if (hs_c) begin
               occ_n  = 2'd0;
            end
         end
         2'd2: begin
            if (hs_c) begin
               head_n = tail_q;
               occ_n  = 2'd1;
            end
         end
         default: begin
            occ_n = 2'd0;
         end
      endcase
   end

   // State, datapath and registered outputs
   always_ff @(posedge rclk or negedge rrst_n) begin
      if (!rrst_n) begin
         state_q    <= S_IDLE;
         rem_pop_q  <= '0;
         rem_out_q  <= '0;
         rd_count_q <= '0;
         occ_q      <= 2'd0;
         head_q     <= '0;
         tail_q     <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         m_valid_q  <= 1'b0;
         m_last_q   <= 1'b0;
      end else begin
         state_q    <= state_n;
         rem_pop_q  <= rem_pop_n;
         rem_out_q  <= rem_out_n;
         rd_count_q <= rd_count_n;
         occ_q      <= occ_n;
         head_q     <= head_n;
         tail_q     <= tail_n;
         busy_q     <= (state_n == S_DRAIN) || (state_n == S_FLUSH);
         done_q     <= (state_n == S_DONE);
         m_valid_q  <= (occ_n != 2'd0);
         m_last_q   <= (occ_n != 2'd0) && (rem_out_n == LW'(1));
      end
   end

   assign rinc     = rinc_c;
   assign busy     = busy_q;
   assign done     = done_q;
   assign m_valid  = m_valid_q;
   assign m_data   = head_q;
   assign m_last   = m_last_q;
   assign rd_count = rd_count_q;

endmodule

// File: tb/tb_async_fifo_rd_drain.sv
// Directed bench for async_fifo_rd_drain with a queue model of the FIFO.
module tb_async_fifo_rd_drain;

   localparam int unsigned DW = 8;
   localparam int unsigned LW = 16;

   logic          rclk = 1'b0;
   logic          rrst_n;
   logic          start;
   logic [LW-1:0] xfer_len;
   logic          busy, done;
   logic          rempty = 1'b1;
   logic          rinc;
   logic [DW-1:0] rdata = '0;
   logic          m_valid, m_ready, m_last;
   logic [DW-1:0] m_data;
   logic [LW-1:0] rd_count;

   always #5 rclk = ~rclk;

   async_fifo_rd_drain #(.FIFO_DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
      .rclk(rclk), .rrst_n(rrst_n), .start(start), .xfer_len(xfer_len),
      .busy(busy), .done(done), .rempty(rempty), .rinc(rinc), .rdata(rdata),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
      .rd_count(rd_count)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // FIFO model: only this block writes the queue and the read-port signals
   logic [DW-1:0] fq[$];
   logic          pop_pend = 1'b0;
   logic          push_req = 1'b0;
   logic [DW-1:0] push_val = '0;
   logic          flush_req = 1'b0;

   always @(posedge rclk) begin
      #1;
      if (flush_req) begin
         fq.delete();
      end else begin
         if (pop_pend && fq.size() > 0) void'(fq.pop_front());
         if (push_req) fq.push_back(push_val);
      end
      rempty = (fq.size() == 0);
      rdata  = (fq.size() > 0) ? fq[0] : '0;
   end

   // Monitor on the falling edge, away from the active edge
   int            cyc = 0;
   int            pops = 0;
   int            viol = 0;
   int            hs_cnt = 0;
   int            hs_last = 0;
   int            done_cnt = 0;
   int            done_cyc = 0;
   logic [DW-1:0] rx_data[$];
   logic          rx_last[$];

   always @(negedge rclk) begin
      cyc++;
      pop_pend = rinc;
      if (rinc) pops++;
      if (rinc && rempty) viol++;
      if (rrst_n && m_valid && m_ready) begin
         rx_data.push_back(m_data);
         rx_last.push_back(m_last);
         hs_cnt++;
         hs_last = cyc;
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
   end

   task automatic tick();
      @(posedge rclk);
      #2;
   endtask

   task automatic push_word(input logic [DW-1:0] v);
      push_req = 1'b1;
      push_val = v;
      tick();
      push_req = 1'b0;
   endtask

   task automatic flush_fifo();
      flush_req = 1'b1;
      tick();
      flush_req = 1'b0;
      tick();
   endtask

   // Leaves the bench in the cycle right after the accepting edge
   task automatic pulse_start(input logic [LW-1:0] len);
      start    = 1'b1;
      xfer_len = len;
      tick();
      start    = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int  base = done_cnt;
      bit  seen = 0;
      for (int i = 0; i < budget; i++) begin
         if (done_cnt > base) begin
            seen = 1;
            break;
         end
         tick();
      end
      check_eq(tag, 32'(seen), 32'd1);
   endtask

   task automatic check_rx(input string tag, input int base, input int n, input logic [DW-1:0] first);
      check_eq({tag, "_count"}, 32'(rx_data.size() - base), 32'(n));
      for (int i = 0; i < n; i++) begin
         if (base + i < rx_data.size()) begin
            check_eq($sformatf("%s_data%0d", tag, i), 32'(rx_data[base+i]), 32'(DW'(first + DW'(i))));
            check_eq($sformatf("%s_last%0d", tag, i), 32'(rx_last[base+i]), 32'(i == n - 1));
         end
      end
   endtask

   initial begin
      int            rb, pb, db, vb, hb;
      bit            got;
      logic [DW-1:0] e0;

      rrst_n   = 1'b0;
      start    = 1'b0;
      xfer_len = '0;
      m_ready  = 1'b0;
      repeat (3) tick();

      // Reset values
      check_eq("rst_busy",     32'(busy),     32'd0);
      check_eq("rst_done",     32'(done),     32'd0);
      check_eq("rst_rinc",     32'(rinc),     32'd0);
      check_eq("rst_m_valid",  32'(m_valid),  32'd0);
      check_eq("rst_m_data",   32'(m_data),   32'd0);
      check_eq("rst_m_last",   32'(m_last),   32'd0);
      check_eq("rst_rd_count", 32'(rd_count), 32'd0);
      rrst_n = 1'b1;
      tick();

      // T1: A,B,C,D streamed back to back
      for (int i = 0; i < 4; i++) push_word(DW'(8'h41 + i));
      tick();
      m_ready = 1'b1;
      pulse_start(LW'(4));
      for (int i = 0; i < 7; i++) begin
         check_eq($sformatf("t1_rinc_c%0d", i), 32'(rinc), 32'(i < 4));
         check_eq($sformatf("t1_valid_c%0d", i), 32'(m_valid), 32'(i >= 1 && i <= 4));
         if (i >= 1 && i <= 4) begin
            check_eq($sformatf("t1_data_c%0d", i), 32'(m_data), 32'(8'h41 + i - 1));
            check_eq($sformatf("t1_last_c%0d", i), 32'(m_last), 32'(i == 4));
         end
         check_eq($sformatf("t1_done_c%0d", i), 32'(done), 32'(i == 6));
         tick();
      end
      check_eq("t1_rd_count", 32'(rd_count), 32'd4);
      check_eq("t1_busy", 32'(busy), 32'd0);

      // T2: downstream stalled, buffer fills to 2 then popping stops
      m_ready = 1'b0;
      for (int i = 0; i < 6; i++) push_word(DW'(8'h10 + i));
      tick();
      rb = rx_data.size();
      pb = pops;
      pulse_start(LW'(3));
      repeat (5) tick();
      check_eq("t2_pops_stalled", 32'(pops - pb), 32'd2);
      check_eq("t2_rinc_stalled", 32'(rinc), 32'd0);
      check_eq("t2_valid_stalled", 32'(m_valid), 32'd1);
      check_eq("t2_data_held", 32'(m_data), 32'h10);
      check_eq("t2_last_held", 32'(m_last), 32'd0);
      tick();
      check_eq("t2_data_held2", 32'(m_data), 32'h10);
      m_ready = 1'b1;
      wait_done("t2_done_timeout", 20);
      check_rx("t2_rx", rb, 3, 8'h10);
      check_eq("t2_pops", 32'(pops - pb), 32'd3);
      check_eq("t2_fifo_left", 32'(fq.size()), 32'd3);
      check_eq("t2_rd_count", 32'(rd_count), 32'd3);

      // T3: slow writer, one word every 3 cycles into an empty FIFO
      flush_fifo();
      tick();
      rb = rx_data.size();
      vb = viol;
      db = done_cnt;
      pulse_start(LW'(5));
      for (int i = 0; i < 5; i++) begin
         push_word(DW'(8'h20 + i));
         tick();
         tick();
      end
      wait_done("t3_done_timeout", 20);
      check_eq("t3_rinc_while_empty", 32'(viol - vb), 32'd0);
      check_rx("t3_rx", rb, 5, 8'h20);
      check_eq("t3_done_count", 32'(done_cnt - db), 32'd1);
      check_eq("t3_done_after_last_hs", 32'(done_cyc - hs_last), 32'd2);
      check_eq("t3_fifo_left", 32'(fq.size()), 32'd0);

      // T4: zero-length transfer
      tick();
      pb = pops;
      rb = rx_data.size();
      pulse_start(LW'(0));
      check_eq("t4_done", 32'(done), 32'd1);
      check_eq("t4_busy", 32'(busy), 32'd0);
      check_eq("t4_rinc", 32'(rinc), 32'd0);
      check_eq("t4_valid", 32'(m_valid), 32'd0);
      tick();
      check_eq("t4_done_once", 32'(done), 32'd0);
      check_eq("t4_rd_count", 32'(rd_count), 32'd0);
      check_eq("t4_pops", 32'(pops - pb), 32'd0);
      check_eq("t4_rx", 32'(rx_data.size() - rb), 32'd0);

      // T5: start reissued while busy is ignored
      for (int i = 0; i < 8; i++) push_word(DW'(8'h30 + i));
      tick();
      rb = rx_data.size();
      db = done_cnt;
      pulse_start(LW'(3));
      tick();
      check_eq("t5_busy", 32'(busy), 32'd1);
      pulse_start(LW'(6));
      wait_done("t5_done_timeout", 20);
      repeat (4) tick();
      check_rx("t5_rx", rb, 3, 8'h30);
      check_eq("t5_rd_count", 32'(rd_count), 32'd3);
      check_eq("t5_fifo_left", 32'(fq.size()), 32'd5);
      check_eq("t5_done_count", 32'(done_cnt - db), 32'd1);
      check_eq("t5_idle", 32'(busy), 32'd0);

      // T6: reset after two of eight words, then a fresh transfer
      flush_fifo();
      for (int i = 0; i < 8; i++) push_word(DW'(8'h50 + i));
      tick();
      hb = hs_cnt;
      db = done_cnt;
      pulse_start(LW'(8));
      got = 0;
      for (int i = 0; i < 20; i++) begin
         if (hs_cnt - hb >= 2) begin
            got = 1;
            break;
         end
         tick();
      end
      check_eq("t6_hs_wait", 32'(got), 32'd1);
      rrst_n = 1'b0;
      #1;
      check_eq("t6_rst_busy",     32'(busy),     32'd0);
      check_eq("t6_rst_rinc",     32'(rinc),     32'd0);
      check_eq("t6_rst_valid",    32'(m_valid),  32'd0);
      check_eq("t6_rst_data",     32'(m_data),   32'd0);
      check_eq("t6_rst_last",     32'(m_last),   32'd0);
      check_eq("t6_rst_rd_count", 32'(rd_count), 32'd0);
      tick();
      tick();
      check_eq("t6_no_done", 32'(done_cnt - db), 32'd0);
      rrst_n = 1'b1;
      tick();
      tick();
      check_eq("t6_fifo_has_words", 32'(fq.size() >= 2), 32'd1);
      e0 = (fq.size() > 0) ? fq[0] : '0;
      rb = rx_data.size();
      pulse_start(LW'(2));
      wait_done("t6_done_timeout", 20);
      check_rx("t6_rx", rb, 2, e0);
      check_eq("t6_rd_count", 32'(rd_count), 32'd2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Absolute time limit so the run always ends
   initial begin
      #200000;
      $display("FAIL global_timeout: got timeout expected finish");
      $fatal(1, "timeout");
   end

endmodule
